// File: rtl/regfile_writeback_queue_pkg.sv
// Shared register-file geometry and writeback-queue types.
// Used by both the register file and the writeback queue.
package regfile_writeback_queue_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned WBQ_DEPTH = 4;

    // Queue activity in one cycle, encoded as {pop, push}.
    typedef enum logic [1:0] {
        WBQ_IDLE = 2'b00,
        WBQ_PUSH = 2'b01,
        WBQ_POP  = 2'b10,
        WBQ_BOTH = 2'b11
    } wbq_op_e;

    function automatic wbq_op_e wbq_op(input logic push, input logic pop);
        return wbq_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/regfile_writeback_queue_forward.sv
// Read-port forwarding for the writeback queue: picks the youngest valid
// queued write that targets the queried register, else the regfile data.
module wbq_forward_mux
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = WBQ_DEPTH,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DATA_W = RF_DATA_W
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_reg_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data_i,
    input  logic [DEPTH-1:0]             ent_valid_i,
    input  logic [$clog2(DEPTH)-1:0]     head_i,
    input  logic [ADDR_W-1:0]            query_i,
    input  logic [DATA_W-1:0]            fallback_i,
    output logic [DATA_W-1:0]            data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        data_o = fallback_i;
        idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (ent_valid_i[idx] && (ent_reg_i[idx] == query_i)) begin
                data_o = ent_data_i[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue in front of the 32x32 register file: buffers writes, drains
// one per cycle onto the regfile write port and forwards pending data to reads.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = WBQ_DEPTH,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned DATA_W = RF_DATA_W
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_hold,
    output logic                     ctrl_writeEnable,
    output logic [ADDR_W-1:0]        ctrl_writeReg,
    output logic [DATA_W-1:0]        data_writeReg,
    input  logic [ADDR_W-1:0]        ctrl_readRegA,
    input  logic [DATA_W-1:0]        rf_dataA,
    output logic [DATA_W-1:0]        data_readRegA,
    input  logic [ADDR_W-1:0]        ctrl_readRegB,
    input  logic [DATA_W-1:0]        rf_dataB,
    output logic [DATA_W-1:0]        data_readRegB,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] reg_q, reg_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [PTR_W-1:0]             tail_q, tail_d;
    logic [CNT_W-1:0]             count_q, count_d;

    logic    push;
    logic    pop;
    wbq_op_e op;

    // Full blocks acceptance even when the head drains this cycle.
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign in_ready = !full;
    assign count    = count_q;

    assign push = in_valid && !full;
    assign pop  = !empty && !wb_hold;
    assign op   = wbq_op(push, pop);

    assign ctrl_writeEnable = pop;
    assign ctrl_writeReg    = empty ? '0 : reg_q[head_q];
    assign data_writeReg    = empty ? '0 : data_q[head_q];

    always_comb begin
        reg_d   = reg_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        // Push and pop never share a slot: push needs !full, pop needs !empty.
        if (push) begin
            reg_d[tail_q]   = in_reg;
            data_d[tail_q]  = in_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end

        case (op)
            WBQ_PUSH: count_d = count_q + CNT_W'(1);
            WBQ_POP:  count_d = count_q - CNT_W'(1);
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            reg_q   <= '0;
            data_q  <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            reg_q   <= reg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    wbq_forward_mux #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_a (
        .ent_reg_i   (reg_q),
        .ent_data_i  (data_q),
        .ent_valid_i (valid_q),
        .head_i      (head_q),
        .query_i     (ctrl_readRegA),
        .fallback_i  (rf_dataA),
        .data_o      (data_readRegA)
    );

    wbq_forward_mux #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_b (
        .ent_reg_i   (reg_q),
        .ent_data_i  (data_q),
        .ent_valid_i (valid_q),
        .head_i      (head_q),
        .query_i     (ctrl_readRegB),
        .fallback_i  (rf_dataB),
        .data_o      (data_readRegB)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue with an attached regfile
// and a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        wb_hold;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [31:0] rf_dataA;
    logic [31:0] data_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] rf_dataB;
    logic [31:0] data_readRegB;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    always #5 clock = ~clock;

    regfile_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_reg           (in_reg),
        .in_data          (in_data),
        .wb_hold          (wb_hold),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .rf_dataA         (rf_dataA),
        .data_readRegA    (data_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .rf_dataB         (rf_dataB),
        .data_readRegB    (data_readRegB),
        .count            (count),
        .empty            (empty),
        .full             (full)
    );

    // Attached register file; unwritten registers read a recognisable pattern.
    logic [31:0] rf_mem [32];
    logic [31:0] rf_written = '0;

    function automatic logic [31:0] rf_init(input logic [4:0] r);
        return 32'hA000_0000 | {27'd0, r};
    endfunction

    always @(posedge clock) begin
        if (ctrl_writeEnable) begin
            rf_mem[ctrl_writeReg]     <= data_writeReg;
            rf_written[ctrl_writeReg] <= 1'b1;
        end
    end

    assign rf_dataA = rf_written[ctrl_readRegA] ? rf_mem[ctrl_readRegA] : rf_init(ctrl_readRegA);
    assign rf_dataB = rf_written[ctrl_readRegB] ? rf_mem[ctrl_readRegB] : rf_init(ctrl_readRegB);

    function automatic logic [31:0] rf_peek(input logic [4:0] r);
        return rf_written[r] ? rf_mem[r] : rf_init(r);
    endfunction

    // Reference model: pending writes in acceptance order plus expected regfile.
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] exp_rf [32];
    logic        m_push;
    logic        m_pop;
    ent_t        m_ent;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check(input logic v, input logic [4:0] r, input logic [31:0] d,
                               input logic h, input logic [4:0] ra, input logic [4:0] rb);
        int          sz;
        logic [31:0] ea;
        logic [31:0] eb;
        sz = mq.size();
        ea = exp_rf[ra];
        eb = exp_rf[rb];
        foreach (mq[i]) begin
            if (mq[i].r == ra) ea = mq[i].d;
            if (mq[i].r == rb) eb = mq[i].d;
        end
        chk("count", {29'd0, count}, 32'(sz));
        chk_b("empty", empty, sz == 0);
        chk_b("full", full, sz == DEPTH);
        chk_b("in_ready", in_ready, sz < DEPTH);
        chk_b("write_enable", ctrl_writeEnable, (sz > 0) && !h);
        chk("write_reg", {27'd0, ctrl_writeReg}, (sz > 0) ? {27'd0, mq[0].r} : 32'd0);
        chk("write_data", data_writeReg, (sz > 0) ? mq[0].d : 32'd0);
        chk("fwd_a", data_readRegA, ea);
        chk("fwd_b", data_readRegB, eb);
        m_pop  = (sz > 0) && !h;
        m_push = v && (sz < DEPTH);
        m_ent  = '{r: r, d: d};
    endtask

    // Drive at posedge+1, check combinational outputs just after the negedge.
    task automatic apply(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic h, input logic [4:0] ra, input logic [4:0] rb);
        in_valid      = v;
        in_reg        = r;
        in_data       = d;
        wb_hold       = h;
        ctrl_readRegA = ra;
        ctrl_readRegB = rb;
        @(negedge clock);
        #1;
        model_check(v, r, d, h, ra, rb);
    endtask

    task automatic advance();
        @(posedge clock);
        if (m_pop) begin
            exp_rf[mq[0].r] = mq[0].d;
            void'(mq.pop_front());
        end
        if (m_push) mq.push_back(m_ent);
        m_pop  = 1'b0;
        m_push = 1'b0;
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", {29'd0, count}, 32'd0);
        chk_b("rst_we", ctrl_writeEnable, 1'b0);
        chk_b("rst_empty", empty, 1'b1);
        chk_b("rst_full", full, 1'b0);
        chk_b("rst_in_ready", in_ready, 1'b1);
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
        logic        h;
        logic [4:0]  ra;
        int          e_cnt;
        logic        e_full;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [31:0] e_fa;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fill with hold, overflow attempt, forward priority, then in-order drain.
        tbl[0]  = '{1'b1, 5'd7,  32'h1,  1'b1, 5'd7,  0, 1'b0, 1'b0, 5'd0,  32'h0,  32'hA000_0007};
        tbl[1]  = '{1'b1, 5'd7,  32'h2,  1'b1, 5'd7,  1, 1'b0, 1'b0, 5'd7,  32'h1,  32'h1};
        tbl[2]  = '{1'b1, 5'd9,  32'h33, 1'b1, 5'd7,  2, 1'b0, 1'b0, 5'd7,  32'h1,  32'h2};
        tbl[3]  = '{1'b1, 5'd10, 32'h44, 1'b1, 5'd7,  3, 1'b0, 1'b0, 5'd7,  32'h1,  32'h2};
        tbl[4]  = '{1'b1, 5'd11, 32'h55, 1'b1, 5'd7,  4, 1'b1, 1'b0, 5'd7,  32'h1,  32'h2};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd11, 4, 1'b1, 1'b0, 5'd7,  32'h1,  32'hA000_000B};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd7,  4, 1'b1, 1'b1, 5'd7,  32'h1,  32'h2};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd7,  3, 1'b0, 1'b1, 5'd7,  32'h2,  32'h2};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd7,  2, 1'b0, 1'b1, 5'd9,  32'h33, 32'h2};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd9,  1, 1'b0, 1'b1, 5'd10, 32'h44, 32'h33};
        tbl[10] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd10, 0, 1'b0, 1'b0, 5'd0,  32'h0,  32'h44};

        for (int i = 0; i < 32; i++) exp_rf[i] = rf_init(5'(i));
        m_pop         = 1'b0;
        m_push        = 1'b0;
        m_ent         = '0;
        ctrl_reset_n  = 1'b0;
        in_valid      = 1'b0;
        in_reg        = '0;
        in_data       = '0;
        wb_hold       = 1'b0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        #12;
        chk_reset_outputs();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Reset mid-queue and mid-drain discards entries without writing.
        apply(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 5'd4); advance();
        apply(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 5'd4); advance();
        apply(1'b0, 5'd0, 32'h0,  1'b0, 5'd3, 5'd4);
        ctrl_reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        mq.delete();
        m_pop  = 1'b0;
        m_push = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rf_r3_after_reset", rf_peek(5'd3), 32'hA000_0003);
        chk("rf_r4_after_reset", rf_peek(5'd4), 32'hA000_0004);
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4); advance();

        // Single write latency.
        apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd5, 5'd0); advance();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
        chk_b("single_we", ctrl_writeEnable, 1'b1);
        chk("single_wreg", {27'd0, ctrl_writeReg}, 32'd5);
        chk("single_wdata", data_writeReg, 32'hDEAD_BEEF);
        advance();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0);
        chk_b("single_empty_after", empty, 1'b1);
        chk("single_rf_r5", rf_peek(5'd5), 32'hDEAD_BEEF);
        advance();

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].h, tbl[i].ra, 5'd8);
            chk($sformatf("tbl%0d_count", i), {29'd0, count}, 32'(tbl[i].e_cnt));
            chk_b($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
            chk_b($sformatf("tbl%0d_in_ready", i), in_ready, !tbl[i].e_full);
            chk_b($sformatf("tbl%0d_we", i), ctrl_writeEnable, tbl[i].e_we);
            chk($sformatf("tbl%0d_wreg", i), {27'd0, ctrl_writeReg}, {27'd0, tbl[i].e_wr});
            chk($sformatf("tbl%0d_wdata", i), data_writeReg, tbl[i].e_wd);
            chk($sformatf("tbl%0d_fwd_a", i), data_readRegA, tbl[i].e_fa);
            chk($sformatf("tbl%0d_fwd_b", i), data_readRegB, 32'hA000_0008);
            advance();
        end

        // Head entry forwarded while it drains, then from the regfile.
        apply(1'b1, 5'd9, 32'h55, 1'b0, 5'd9, 5'd0); advance();
        apply(1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 5'd0);
        chk_b("head_fwd_we", ctrl_writeEnable, 1'b1);
        chk("head_fwd_a", data_readRegA, 32'h55);
        advance();
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd0);
        chk("head_fwd_a_rf", data_readRegA, 32'h55);
        chk_b("head_fwd_empty", empty, 1'b1);
        advance();

        // Push and pop together at count 2.
        apply(1'b1, 5'd1, 32'h101, 1'b1, 5'd1, 5'd2); advance();
        apply(1'b1, 5'd2, 32'h202, 1'b1, 5'd1, 5'd2); advance();
        apply(1'b1, 5'd3, 32'h303, 1'b0, 5'd1, 5'd2);
        chk("pp_count_before", {29'd0, count}, 32'd2);
        advance();
        apply(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd1);
        chk("pp_count_after", {29'd0, count}, 32'd2);
        chk("pp_head_reg", {27'd0, ctrl_writeReg}, 32'd2);
        advance();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd3);
            advance();
        end

        // Random traffic against the reference model; pointers wrap many times.
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 5'd0, 32'h0, 1'b0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("final_rf_r%0d", i), rf_peek(5'(i)), exp_rf[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
